// File: rtl/asip_top.sv
// ---------------------------------------------------------------------------
// asip_top - VGA test-pattern display engine (640x480@60 from a 50 MHz clock)
//
// Generates VGA timing and a test pattern (colour bars or a 32x32
// checkerboard). Each pixel then goes through a per-channel colour gain and a
// blend toward a mid-grey background. The result drives an ADV7123-style
// video DAC.
//
// Ports:
//   clk                 50 MHz system clock
//   rst                 asynchronous reset, active low
//   red/green/blue_switches [1:0]  per-channel gain code (3 = unity .. 0 = off)
//   tran_switches [1:0] blend level toward grey background (0 = none)
//   gtype_switch        pattern select: 0 colour bars, 1 checkerboard
//   switchStart         1 = bypass effects (raw pattern), 0 = effects on
//   r, g, b [7:0]       pixel colour, forced to 0 while blanked
//   hsync, vsync        active-low sync
//   n_sync              DAC sync-on-green, tied low
//   n_blanc             DAC blank_n, high only in the visible area
//   n25MHZCLK           pixel clock, clk/2
// ---------------------------------------------------------------------------
module asip_top (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] red_switches,
  input  logic [1:0] green_switches,
  input  logic [1:0] blue_switches,
  input  logic [1:0] tran_switches,
  input  logic       gtype_switch,
  input  logic       switchStart,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  output logic       vsync,
  output logic       hsync,
  output logic       n_sync,
  output logic       n_blanc,
  output logic       n25MHZCLK
);

  localparam logic [9:0] H_VIS      = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd752;
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_VIS      = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd492;
  localparam logic [9:0] V_LAST     = 10'd524;

  // Settings word layout: {bypass, gtype, tran[1:0], blue[1:0], green[1:0], red[1:0]}.
  // The reset value selects bypass with colour bars. The synchronisers reset to
  // the same value, so the first frame after reset always shows raw bars.
  localparam logic [9:0] SET_RST = 10'b10_0000_0000;

  logic       r_pclk;
  logic       w_pe;
  logic [9:0] w_sw;
  logic [9:0] r_sync1;
  logic [9:0] r_sync2;
  logic [9:0] r_set;
  logic [9:0] w_set;
  logic       w_frame_start;
  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       w_bypass;
  logic       w_gtype;
  logic [1:0] w_tran;
  logic [2:0] w_bar;
  logic       w_cb_white;
  logic       w_vis;
  logic [2:0][7:0] w_blend;
  logic [7:0] r_red;
  logic [7:0] r_grn;
  logic [7:0] r_blu;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;

  // Pixel clock divider. The pixel enable fires in the cycle where the
  // divided clock is still low, that is, just before its rising toggle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pclk <= 1'b0;
    else      r_pclk <= ~r_pclk;
  end

  assign w_pe = ~r_pclk;

  assign w_sw = {switchStart, gtype_switch, tran_switches,
                 blue_switches, green_switches, red_switches};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= SET_RST;
      r_sync2 <= SET_RST;
    end else begin
      r_sync1 <= w_sw;
      r_sync2 <= r_sync1;
    end
  end

  // Raster counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pe) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  assign w_frame_start = w_pe && (r_h == 10'd0) && (r_v == 10'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_set <= SET_RST;
    else if (w_frame_start) r_set <= r_sync2;
  end

  // Pixel (0,0) is rendered on the same pe that loads the settings. The
  // incoming value is forwarded here so that the whole frame uses one setting.
  assign w_set    = w_frame_start ? r_sync2 : r_set;
  assign w_bypass = w_set[9];
  assign w_gtype  = w_set[8];
  assign w_tran   = w_bypass ? 2'd0 : w_set[7:6];

  // Bar index h/80. Only the visible range (0..7) is ever displayed, so the
  // truncation of 8 and 9 in the blanking region does no harm.
  assign w_bar      = 3'(r_h / 10'd80);
  assign w_cb_white = ~(r_h[5] ^ r_v[5]);

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [7:0] w_pat;
    logic [1:0] w_code;
    logic [7:0] w_gain;
    logic [9:0] w_q10;
    logic [7:0] w_res;

    assign w_pat  = w_gtype ? {8{w_cb_white}} : {8{w_bar[gi]}};
    assign w_code = w_bypass ? 2'd3 : w_set[2*gi +: 2];

    always_comb begin
      w_gain = 8'd0;
      case (w_code)
        2'd3:    w_gain = w_pat;
        2'd2:    w_gain = w_pat >> 1;
        2'd1:    w_gain = w_pat >> 2;
        default: w_gain = 8'd0;
      endcase
    end

    // Blend toward background 128. The 10-bit sum never overflows (at most
    // 3*255+128 = 893), and the shift floors the result.
    assign w_q10 = {2'b00, w_gain};

    always_comb begin
      w_res = w_gain;
      case (w_tran)
        2'd0:    w_res = w_gain;
        2'd1:    w_res = 8'((w_q10 * 10'd3 + 10'd128) >> 2);
        2'd2:    w_res = 8'((w_q10 + 10'd128) >> 1);
        default: w_res = 8'((w_q10 + 10'd384) >> 2);
      endcase
    end

    assign w_blend[gi] = w_res;
  end

  assign w_vis = (r_h < H_VIS) && (r_v < V_VIS);

  // Output stage. Every output here shows the raster position present at
  // this pe, so colour, sync and blank stay mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_red     <= 8'd0;
      r_grn     <= 8'd0;
      r_blu     <= 8'd0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_pe) begin
      r_red     <= w_vis ? w_blend[0] : 8'd0;
      r_grn     <= w_vis ? w_blend[1] : 8'd0;
      r_blu     <= w_vis ? w_blend[2] : 8'd0;
      r_hsync   <= ~((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
      r_vsync   <= ~((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
      r_blank_n <= w_vis;
    end
  end

  assign r         = r_red;
  assign g         = r_grn;
  assign b         = r_blu;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign n_blanc   = r_blank_n;
  assign n_sync    = 1'b0;
  assign n25MHZCLK = r_pclk;

endmodule

// File: tb/tb_asip_top.sv
module tb_asip_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] red_sw = 2'd0, green_sw = 2'd0, blue_sw = 2'd0, tran_sw = 2'd0;
  logic       gtype_sw = 1'b0, ss_sw = 1'b0;
  logic [7:0] r, g, b;
  logic       vsync, hsync, n_sync, n_blanc, n25MHZCLK;

  asip_top dut (
    .clk            (clk),
    .rst            (rst),
    .red_switches   (red_sw),
    .green_switches (green_sw),
    .blue_switches  (blue_sw),
    .tran_switches  (tran_sw),
    .gtype_switch   (gtype_sw),
    .switchStart    (ss_sw),
    .r              (r),
    .g              (g),
    .b              (b),
    .vsync          (vsync),
    .hsync          (hsync),
    .n_sync         (n_sync),
    .n_blanc        (n_blanc),
    .n25MHZCLK      (n25MHZCLK)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int h;
    int v;
    int er;
    int eg;
    int eb;
  } exp_t;
  exp_t sb[$];

  // Settings the display should be using in the current frame
  int a_ss, a_gt, a_tr, a_gr, a_gg, a_gb;
  bit at_release;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_sw(input int rs, input int gs, input int bs, input int ts,
                        input int gt, input int ss);
    red_sw   = 2'(rs);
    green_sw = 2'(gs);
    blue_sw  = 2'(bs);
    tran_sw  = 2'(ts);
    gtype_sw = 1'(gt);
    ss_sw    = 1'(ss);
  endtask

  // Expected colour of one channel (0=r,1=g,2=b) at raster position (h,v)
  function automatic int exp_chan(input int ch, input int h, input int v);
    int p, q, code, t;
    if (!(h < 640 && v < 480)) return 0;
    if (a_gt == 0) p = (((h / 80) >> ch) & 1) != 0 ? 255 : 0;
    else           p = (((h >> 5) ^ (v >> 5)) & 1) == 0 ? 255 : 0;
    if (a_ss != 0)    code = 3;
    else if (ch == 0) code = a_gr;
    else if (ch == 1) code = a_gg;
    else              code = a_gb;
    case (code)
      3:       q = p;
      2:       q = p / 2;
      1:       q = p / 4;
      default: q = 0;
    endcase
    t = (a_ss != 0) ? 0 : a_tr;
    case (t)
      0:       return q;
      1:       return (3 * q + 128) / 4;
      2:       return (q + 128) / 2;
      default: return (q + 384) / 4;
    endcase
  endfunction

  function automatic bit is_cp(input int fr, input int h, input int v);
    case (fr)
      1: return (h == 0 && v == 0) || (h == 100 && v == 0) || (h == 200 && v == 0) ||
                (h == 560 && v == 5) || (h == 700 && v == 10) || (h == 300 && v == 500);
      2: return (h == 0 && v == 10) || (h == 100 && v == 10) || (h == 700 && v == 10) ||
                (h == 100 && v == 300) || (h == 300 && v == 500);
      3: return (h == 100 && v == 10) || (h == 0 && v == 0) || (h == 500 && v == 200);
      4: return (h == 0 && v == 0) || (h == 32 && v == 0) || (h == 32 && v == 32) ||
                (h == 64 && v == 33);
      5: return (h == 0 && v == 0) || (h == 100 && v == 0) || (h == 700 && v == 0);
      default: return 1'b0;
    endcase
  endfunction

  // Move to the falling edge just after the next pixel-enable edge
  task automatic step_pixel();
    if (at_release) begin
      @(negedge clk);
      at_release = 1'b0;
    end else begin
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int fr, input int npix, input bit full, input bit after_reset);
    int hs_low, vs_low, bl_hi, mism, first_hs, line0_hs;
    int h, v, er, eg, eb;
    bit cp, ehs, evs, ebl;
    exp_t e;
    hs_low = 0; vs_low = 0; bl_hi = 0; mism = 0; first_hs = -1; line0_hs = 0;
    if (after_reset) begin
      a_ss = 1; a_gt = 0; a_tr = 0; a_gr = 0; a_gg = 0; a_gb = 0;
    end else begin
      a_ss = int'(ss_sw); a_gt = int'(gtype_sw); a_tr = int'(tran_sw);
      a_gr = int'(red_sw); a_gg = int'(green_sw); a_gb = int'(blue_sw);
    end
    for (int k = 0; k < npix; k++) begin
      h = k % 800;
      v = k / 800;
      if (fr == 1 && v == 100 && h == 0) set_sw(3, 0, 0, 1, 0, 0);
      if (fr == 2 && v == 200 && h == 0) set_sw(1, 0, 0, 0, 0, 0);
      if (fr == 3 && v == 100 && h == 0) set_sw(0, 1, 2, 0, 1, 1);
      er  = exp_chan(0, h, v);
      eg  = exp_chan(1, h, v);
      eb  = exp_chan(2, h, v);
      ehs = !(h >= 656 && h <= 751);
      evs = !(v == 490 || v == 491);
      ebl = (h < 640 && v < 480);
      cp  = is_cp(fr, h, v);
      if (cp) sb.push_back('{h, v, er, eg, eb});
      step_pixel();
      if (r !== 8'(er) || g !== 8'(eg) || b !== 8'(eb) || hsync !== ehs ||
          vsync !== evs || n_blanc !== ebl || n_sync !== 1'b0 || n25MHZCLK !== 1'b1)
        mism++;
      if (hsync === 1'b0) begin
        hs_low++;
        if (first_hs < 0) first_hs = k;
        if (k < 800) line0_hs++;
      end
      if (vsync === 1'b0) vs_low++;
      if (n_blanc === 1'b1) bl_hi++;
      if (cp) begin
        e = sb.pop_front();
        check($sformatf("f%0d_r_at_%0d_%0d", fr, e.h, e.v), {24'd0, r}, e.er);
        check($sformatf("f%0d_g_at_%0d_%0d", fr, e.h, e.v), {24'd0, g}, e.eg);
        check($sformatf("f%0d_b_at_%0d_%0d", fr, e.h, e.v), {24'd0, b}, e.eb);
        check($sformatf("f%0d_pclk_at_%0d_%0d", fr, e.h, e.v), {31'd0, n25MHZCLK}, 1);
      end
    end
    if (full) begin
      check($sformatf("f%0d_hsync_low_pixels", fr), hs_low, 96 * 525);
      check($sformatf("f%0d_vsync_low_pixels", fr), vs_low, 2 * 800);
      check($sformatf("f%0d_blank_n_high_pixels", fr), bl_hi, 640 * 480);
      if (fr == 1) begin
        check("first_hsync_fall_pixel", first_hs, 656);
        check("line0_hsync_width", line0_hs, 96);
      end
    end
    check($sformatf("f%0d_pixel_model_mismatches", fr), mism, 0);
  endtask

  initial begin
    // Non-bypass switches held through reset: the first frame must still be raw bars
    set_sw(2, 2, 2, 3, 1, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_r", {24'd0, r}, 0);
    check("rst_g", {24'd0, g}, 0);
    check("rst_b", {24'd0, b}, 0);
    check("rst_hsync", {31'd0, hsync}, 1);
    check("rst_vsync", {31'd0, vsync}, 1);
    check("rst_n_blanc", {31'd0, n_blanc}, 0);
    check("rst_n_sync", {31'd0, n_sync}, 0);
    check("rst_pclk", {31'd0, n25MHZCLK}, 0);

    rst = 1'b1;
    at_release = 1'b1;
    run_frame(1, 420000, 1'b1, 1'b1);
    run_frame(2, 420000, 1'b1, 1'b0);
    run_frame(3, 420000, 1'b1, 1'b0);
    // Stop on pixel (40,40), which is white, then reset asynchronously
    run_frame(4, 40 * 800 + 41, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_r", {24'd0, r}, 0);
    check("midrst_g", {24'd0, g}, 0);
    check("midrst_b", {24'd0, b}, 0);
    check("midrst_hsync", {31'd0, hsync}, 1);
    check("midrst_vsync", {31'd0, vsync}, 1);
    check("midrst_n_blanc", {31'd0, n_blanc}, 0);
    check("midrst_pclk", {31'd0, n25MHZCLK}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    at_release = 1'b1;
    run_frame(5, 800, 1'b0, 1'b1);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
